// File: rtl/div_binary_seq_pkg.sv
// Shared arithmetic-unit definitions for the sequential divider: default widths and FSM encoding.
package div_binary_seq_pkg;

    localparam int unsigned DIV_DW = 8;
    localparam int unsigned DIV_VW = 4;
    localparam int unsigned DIV_CW = $clog2(DIV_DW);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring division step: shift in the next dividend bit, subtract the divisor if it fits.
module div_step #(
    parameter int unsigned VW = 4
) (
    input  logic [VW-1:0] rem,
    input  logic          msb,
    input  logic [VW-1:0] divisor,
    output logic [VW-1:0] rem_next,
    output logic          qbit
);

    // One extra bit so the shifted partial remainder never overflows before the compare.
    logic [VW:0] t;

    assign t        = {rem, msb};
    assign qbit     = (t >= {1'b0, divisor});
    assign rem_next = qbit ? VW'(t - {1'b0, divisor}) : t[VW-1:0];

endmodule

// File: rtl/div_binary_seq.sv
// Sequential restoring divider, one quotient bit per clock, with start/ready/done handshake.
module div_binary_seq
    import div_binary_seq_pkg::*;
#(
    parameter int unsigned DW = DIV_DW,
    parameter int unsigned VW = DIV_VW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          ready,
    output logic          done,
    output logic [DW-1:0] q,
    output logic [VW-1:0] r,
    output logic          dbz
);

    localparam int unsigned CW = $clog2(DW);

    state_t        state, state_n;
    logic [VW-1:0] rem, rem_n;
    logic [VW-1:0] dvs, dvs_n;
    logic [DW-1:0] quo, quo_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          ready_n, done_n, dbz_n;
    logic [DW-1:0] q_n;
    logic [VW-1:0] r_n;
    logic [VW-1:0] step_rem;
    logic          step_qbit;

    div_step #(.VW(VW)) u_step (
        .rem      (rem),
        .msb      (quo[DW-1]),
        .divisor  (dvs),
        .rem_next (step_rem),
        .qbit     (step_qbit)
    );

    // Next-state and next-register logic; results only move on the transition into DONE.
    always_comb begin
        state_n = state;
        rem_n   = rem;
        dvs_n   = dvs;
        quo_n   = quo;
        cnt_n   = cnt;
        q_n     = q;
        r_n     = r;
        dbz_n   = dbz;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    dvs_n = divisor;
                    if (divisor == '0) begin
                        state_n = ST_DONE;
                        q_n     = '1;
                        r_n     = '0;
                        dbz_n   = 1'b1;
                    end else begin
                        state_n = ST_CALC;
                        rem_n   = '0;
                        quo_n   = dividend;
                        cnt_n   = CW'(DW - 1);
                    end
                end
            end
            ST_CALC: begin
                rem_n = step_rem;
                quo_n = {quo[DW-2:0], step_qbit};
                if (cnt == '0) begin
                    state_n = ST_DONE;
                    q_n     = {quo[DW-2:0], step_qbit};
                    r_n     = step_rem;
                    dbz_n   = 1'b0;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
        ready_n = (state_n == ST_IDLE);
        done_n  = (state_n == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            rem   <= '0;
            dvs   <= '0;
            quo   <= '0;
            cnt   <= '0;
            ready <= 1'b1;
            done  <= 1'b0;
            q     <= '0;
            r     <= '0;
            dbz   <= 1'b0;
        end else begin
            state <= state_n;
            rem   <= rem_n;
            dvs   <= dvs_n;
            quo   <= quo_n;
            cnt   <= cnt_n;
            ready <= ready_n;
            done  <= done_n;
            q     <= q_n;
            r     <= r_n;
            dbz   <= dbz_n;
        end
    end

endmodule

// File: tb/tb_div_binary_seq.sv
// Scoreboard bench for div_binary_seq: driver queues expected results, negedge monitor checks them.
module tb_div_binary_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] dividend = '0;
    logic [3:0] divisor = '0;
    logic       ready, done, dbz;
    logic [7:0] q;
    logic [3:0] r;

    typedef struct {
        logic [7:0] q;
        logic [3:0] r;
        logic       dbz;
        int         acc;
        int         due;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    logic rst_q = 1'b0;
    logic [7:0] hold_q = '0;
    logic [3:0] hold_r = '0;
    logic       hold_dbz = 1'b0;

    div_binary_seq dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .dividend (dividend),
        .divisor  (divisor),
        .ready    (ready),
        .done     (done),
        .q        (q),
        .r        (r),
        .dbz      (dbz)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // Monitor: reset values, ready handshake, done timing/results, and output stability.
    always @(negedge clk) begin
        if (rst_q) begin
            chk("rst_ready", int'(ready), 1);
            chk("rst_done", int'(done), 0);
            chk("rst_q", int'(q), 0);
            chk("rst_r", int'(r), 0);
            chk("rst_dbz", int'(dbz), 0);
            hold_q = '0;
            hold_r = '0;
            hold_dbz = 1'b0;
        end else if (!rst) begin
            chk("ready", int'(ready), (sb.size() == 0 || sb[0].acc == cyc) ? 1 : 0);
            if (done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("done_cycle", cyc, e.due);
                    chk("q", int'(q), int'(e.q));
                    chk("r", int'(r), int'(e.r));
                    chk("dbz", int'(dbz), int'(e.dbz));
                    hold_q = e.q;
                    hold_r = e.r;
                    hold_dbz = e.dbz;
                end
            end else begin
                chk("hold_q", int'(q), int'(hold_q));
                chk("hold_r", int'(r), int'(hold_r));
                chk("hold_dbz", int'(dbz), int'(hold_dbz));
                if (sb.size() > 0 && cyc > sb[0].due) begin
                    chk("done_timeout", cyc, sb[0].due);
                    void'(sb.pop_front());
                end
            end
        end
    end

    // Reference: plain integer division; divide by zero reports all-ones quotient.
    function automatic exp_t model(input int dd, input int dv, input int acc);
        exp_t e;
        if (dv == 0) begin
            e.q = 8'hFF;
            e.r = 4'd0;
            e.dbz = 1'b1;
            e.due = acc + 1;
        end else begin
            e.q = 8'(dd / dv);
            e.r = 4'(dd % dv);
            e.dbz = 1'b0;
            e.due = acc + 9;
        end
        e.acc = acc;
        return e;
    endfunction

    // Waits for ready (optionally pulsing junk starts meanwhile), issues one op, then scrambles inputs.
    task automatic do_op(input int dd, input int dv, input bit noisy);
        int n = 0;
        while (!ready) begin
            if (n > 40) begin
                chk("ready_timeout", 0, 1);
                return;
            end
            if (noisy) begin
                start = 1'($urandom_range(0, 1));
                dividend = 8'($urandom);
                divisor = 4'($urandom);
            end
            @(posedge clk);
            #1;
            n++;
        end
        start = 1'b1;
        dividend = 8'(dd);
        divisor = 4'(dv);
        sb.push_back(model(dd, dv, cyc));
        @(posedge clk);
        #1;
        start = 1'b0;
        dividend = 8'($urandom);
        divisor = 4'($urandom);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        idle(3);
        rst = 1'b0;
        idle(2);

        do_op(225, 15, 1'b0);
        do_op(200, 7, 1'b0);
        do_op(5, 9, 1'b0);
        do_op(255, 1, 1'b0);
        do_op(0, 15, 1'b0);
        do_op(37, 0, 1'b0);
        do_op(37, 6, 1'b0);
        do_op(100, 3, 1'b0);
        do_op(77, 4, 1'b1);

        // Reset mid-calculation: operation is dropped with no done pulse.
        idle(12);
        do_op(150, 11, 1'b0);
        idle(3);
        rst = 1'b1;
        sb.delete();
        idle(1);
        rst = 1'b0;
        idle(3);

        for (int dd = 0; dd < 256; dd++)
            for (int dv = 0; dv < 16; dv++)
                do_op(dd, dv, 1'b0);

        for (int i = 0; i < 300; i++)
            do_op(int'($urandom_range(0, 255)), int'($urandom_range(0, 15)), 1'b1);

        idle(12);
        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
